// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Sequences every instruction through FETCH/DECODE/execute/memory/writeback.
// It drives the datapath mux selects, the register and memory strobes, and the PC-write enables.
// MemReady stretches FETCH, MEMRD and MEMWR so memory can insert wait states.
//
// Handshake: while the FSM sits in a memory-access state, the access is
// presented and held constant. MemReady=1 in that cycle means the memory
// completes the access at the coming rising edge, and the FSM advances.
// MemReady has no effect in any other state.
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int ENABLE_JUMP = 1,
  parameter int ENABLE_ADDI = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OpCode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State,
  output logic               InstrDone,
  output logic               BranchTaken,
  output logic               IllegalOp
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RCOMP  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  localparam bit JUMP_ON = (ENABLE_JUMP != 0);
  localparam bit ADDI_ON = (ENABLE_ADDI != 0);

  // Ungated control bundle produced from the current state.
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               branch_taken;
    logic               illegal_op;
  } ctl_t;

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctl_t       ctl;
  logic       op_legal;

  // Opcodes that DECODE accepts, including the optional classes.
  assign op_legal = (OpCode == OP_RTYPE) || (OpCode == OP_LW) ||
                    (OpCode == OP_SW) || (OpCode == OP_BEQ) ||
                    (JUMP_ON && (OpCode == OP_J)) ||
                    (ADDI_ON && (OpCode == OP_ADDI));

  // State register: reset abandons any instruction and returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!op_legal)                 state_d = S_FETCH;
        else if (OpCode == OP_RTYPE)   state_d = S_EXEC;
        else if (OpCode == OP_LW ||
                 OpCode == OP_SW)      state_d = S_MEMADR;
        else if (OpCode == OP_BEQ)     state_d = S_BRANCH;
        else if (OpCode == OP_J)       state_d = S_JUMP;
        else                           state_d = S_ADDIEX;
      end
      // The IR holds OpCode stable, so lw/sw is re-examined here.
      S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RCOMP;
      S_RCOMP:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs, qualified only by MemReady (memory states) and Zero (BRANCH).
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = ALU_ADD;
        ctl.ir_write  = MemReady;
        ctl.pc_write  = MemReady;
      end
      S_DECODE: begin
        ctl.alu_src_b  = 2'b11;
        ctl.alu_op     = ALU_ADD;
        ctl.illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = MemReady;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b00;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_RCOMP: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = 2'b00;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.branch_taken  = Zero;
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Gate everything while reset is asserted so no strobe leaks out.
  assign PCWrite     = rst_n & ctl.pc_write;
  assign PCWriteCond = rst_n & ctl.pc_write_cond;
  assign IorD        = rst_n & ctl.iord;
  assign MemRead     = rst_n & ctl.mem_read;
  assign MemWrite    = rst_n & ctl.mem_write;
  assign IRWrite     = rst_n & ctl.ir_write;
  assign MemtoReg    = rst_n & ctl.mem_to_reg;
  assign RegDst      = rst_n & ctl.reg_dst;
  assign RegWrite    = rst_n & ctl.reg_write;
  assign ALUSrcA     = rst_n & ctl.alu_src_a;
  assign ALUSrcB     = rst_n ? ctl.alu_src_b : 2'b00;
  assign PCSource    = rst_n ? ctl.pc_source : 2'b00;
  assign ALUOp       = rst_n ? ctl.alu_op : '0;
  assign State       = rst_n ? state_q : 4'd0;
  assign InstrDone   = rst_n & ctl.instr_done;
  assign BranchTaken = rst_n & ctl.branch_taken;
  assign IllegalOp   = rst_n & ctl.illegal_op;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath, replacing single-cycle opcode decode. Sequences each instruction through fetch, decode, execute, memory and writeback states and drives datapath mux selects, register/memory strobes and PC-write enables. Supports a MemReady handshake so instruction/data memory may insert wait states. Optional instruction classes are enabled by parameters.

## Interface
- ALUOP_W, 4, width of ALUOp; codes: 0000 add, 0001 sub, 0010 funct-decoded, upper bits zero
- ENABLE_JUMP, 1, 1 = decode j (000010); 0 = treat as illegal
- ENABLE_ADDI, 1, 1 = decode addi (001000); 0 = treat as illegal

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- OpCode  in  6  instruction opcode from the instruction register, sampled in DECODE
- Zero  in  1  ALU zero flag, used only externally via PCWriteCond; kept as a port for the InstrDone/BranchTaken status
- MemReady  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  ALUOP_W  ALU operation class
- State  out  4  current state encoding (debug)
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction
- BranchTaken  out  1  high in BRANCH when Zero=1
- IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; 12-15 unreachable, recover to FETCH next cycle with all outputs 0.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp add, PCSource=00; IRWrite=PCWrite=MemReady. Stay until MemReady=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp add. Next: 000000 EXEC; 100011/101011 MEMADR; 000100 BRANCH; 000010 JUMP (if enabled); 001000 ADDIEX (if enabled); otherwise IllegalOp=1, next FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next MEMRD for lw, MEMWR for sw (OpCode held stable by IR).
- MEMRD: MemRead=1, IorD=1; wait for MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; wait for MemReady; InstrDone=MemReady; then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp 0010 -> RCOMP.
- RCOMP: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp sub, PCWriteCond=1, PCSource=01, BranchTaken=Zero, InstrDone=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1 -> FETCH.

## Timing
- State register updates on rising clk; outputs combinational from State (plus MemReady/Zero qualifiers listed above).
- rst_n=0: State forced to FETCH immediately; all outputs gated to 0 (State reads 0). First fetch begins on the first rising edge after rst_n deasserts.
- Reset mid-instruction: abandon instruction, no pending strobe re-issued; no InstrDone.
- Cycles with MemReady always 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2. Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle, controls held constant.
- MemReady ignored outside FETCH/MEMRD/MEMWR.

## Test plan
- Reset: rst_n low mid-EXEC -> State=0, all outputs 0 same cycle; release -> FETCH with MemRead=1, ALUSrcB=01.
- R-type 000000, MemReady=1 -> states 0,1,6,7; ALUOp=0010 in EXEC; RegWrite=RegDst=1 and InstrDone pulse in RCOMP.
- lw 100011 with MemReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; MemRead/IorD held; MemtoReg=RegWrite=1 in MEMWB.
- beq 000100, Zero=1 then repeat with Zero=0 -> 3 cycles each, PCWriteCond=1, PCSource=01, ALUOp=0001; BranchTaken 1 then 0.
- ENABLE_JUMP=0, OpCode=000010 -> IllegalOp pulse in DECODE, no PCWrite, back to FETCH; ENABLE_JUMP=1 -> JUMP with PCWrite=1, PCSource=10.
- sw 101011 with FETCH wait 1 cycle -> 5 cycles total; MemWrite=1 in MEMWR, InstrDone only when MemReady=1.
